unified_transform_scheduler: RTL and testbench

//  Sequences and shares the unified FFT/NTT transform datapath. Three clients use it: transform jobs,
//  the PWM engine (NTT BF0/BF2) and the RNS engine (NTT BF1 + tw-gen multiplier).

---
 rtl/unified_transform_scheduler.sv | 150 +++++++++++++++
 tb/tb_unified_transform_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_transform_scheduler.sv
// Arbitrates the shared FFT/NTT datapath between transform jobs and the PWM/RNS engines.
// Job: start -> drain -> reset -> run -> done/timeout; grants are level req/gnt with 1-cycle latency.
module unified_transform_scheduler #(
  parameter int M            = 17,
  parameter int RST_CYCLES   = 8,
  parameter int DRAIN_CYCLES = 16,
  parameter int TO_W         = 20
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         xf_start_i,
  input  logic         xf_is_fft_i,
  input  logic         xf_is_dif_i,
  input  logic [3:0]   xf_k_i,
  input  logic [1:0]   xf_n_i,
  input  logic [M-1:0] xf_qm_i,
  input  logic [4:0]   xf_const_sel_i,
  output logic         xf_busy_o,
  output logic         xf_done_o,
  output logic         xf_timeout_o,
  input  logic         pwm_req_i,
  output logic         pwm_gnt_o,
  input  logic         rns_req_i,
  output logic         rns_gnt_o,
  output logic         ut_rst_o,
  output logic         ut_rst_pwm_o,
  output logic         ut_is_fft_o,
  output logic         ut_is_dif_o,
  output logic [3:0]   ut_current_k_o,
  output logic [1:0]   ut_current_n_o,
  output logic [M-1:0] ut_qm_o,
  output logic [4:0]   ut_constants_sel_o,
  input  logic         ut_done_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_XF_RST,
    S_XF_RUN,
    S_XF_FIN
  } state_e;

  typedef struct packed {
    logic         is_fft;
    logic         is_dif;
    logic [3:0]   k;
    logic [1:0]   n;
    logic [M-1:0] qm;
    logic [4:0]   const_sel;
  } cfg_t;

  localparam int CNT_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            pwm_gnt_q, pwm_gnt_d;
  logic            rns_gnt_q, rns_gnt_d;
  cfg_t            cfg_q, cfg_d;
  logic            timeout;
  logic            grant_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = '0;
    cfg_d   = cfg_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xf_start_i) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          cfg_d   = '{is_fft: xf_is_fft_i, is_dif: xf_is_dif_i, k: xf_k_i, n: xf_n_i,
                      qm: xf_qm_i, const_sel: xf_const_sel_i};
        end
      end
      S_DRAIN: begin
        // Any grant still held restarts the quiet-period count.
        if (pwm_gnt_q || rns_gnt_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          state_d = S_XF_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XF_RST: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = S_XF_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XF_RUN: begin
        wd_d = wd_q + 1'b1;
        if (ut_done_i) begin
          state_d = S_XF_FIN;
        end else if (wd_q == {TO_W{1'b1}}) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_XF_FIN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // New grants only in IDLE without a competing job start; held grants persist until req drops.
  assign grant_ok  = (state_q == S_IDLE) && !xf_start_i;
  assign pwm_gnt_d = pwm_req_i && (pwm_gnt_q || grant_ok);
  assign rns_gnt_d = rns_req_i && (rns_gnt_q || grant_ok);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wd_q      <= '0;
      pwm_gnt_q <= 1'b0;
      rns_gnt_q <= 1'b0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      pwm_gnt_q <= pwm_gnt_d;
      rns_gnt_q <= rns_gnt_d;
      cfg_q     <= cfg_d;
    end
  end

  assign xf_busy_o          = (state_q != S_IDLE);
  assign xf_done_o          = (state_q == S_XF_FIN);
  assign xf_timeout_o       = timeout;
  assign pwm_gnt_o          = pwm_gnt_q;
  assign rns_gnt_o          = rns_gnt_q;
  assign ut_rst_o           = (state_q != S_XF_RUN);
  assign ut_rst_pwm_o       = ~pwm_gnt_q;
  assign ut_is_fft_o        = cfg_q.is_fft;
  assign ut_is_dif_o        = cfg_q.is_dif;
  assign ut_current_k_o     = cfg_q.k;
  assign ut_current_n_o     = cfg_q.n;
  assign ut_qm_o            = cfg_q.qm;
  assign ut_constants_sel_o = cfg_q.const_sel;

endmodule

// File: tb/tb_unified_transform_scheduler.sv
// Randomized scenario bench for unified_transform_scheduler; expected timing comes from
// the drain/reset/watchdog rules expressed as edge arithmetic.
module tb_unified_transform_scheduler;
  localparam int M       = 17;
  localparam int RST_C   = 8;
  localparam int DRAIN_C = 16;
  localparam int TO_W    = 7;
  localparam int WD_MAX  = (1 << TO_W) - 1;

  typedef struct packed {
    logic         fft;
    logic         dif;
    logic [3:0]   k;
    logic [1:0]   n;
    logic [M-1:0] qm;
    logic [4:0]   cs;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n;
  logic xf_start, xf_is_fft, xf_is_dif;
  logic [3:0] xf_k;
  logic [1:0] xf_n;
  logic [M-1:0] xf_qm;
  logic [4:0] xf_const_sel;
  logic xf_busy, xf_done, xf_timeout;
  logic pwm_req, pwm_gnt, rns_req, rns_gnt;
  logic ut_rst, ut_rst_pwm, ut_is_fft, ut_is_dif;
  logic [3:0] ut_current_k;
  logic [1:0] ut_current_n;
  logic [M-1:0] ut_qm;
  logic [4:0] ut_constants_sel;
  logic ut_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  unified_transform_scheduler #(.M(M), .RST_CYCLES(RST_C), .DRAIN_CYCLES(DRAIN_C), .TO_W(TO_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .xf_start_i(xf_start), .xf_is_fft_i(xf_is_fft), .xf_is_dif_i(xf_is_dif),
    .xf_k_i(xf_k), .xf_n_i(xf_n), .xf_qm_i(xf_qm), .xf_const_sel_i(xf_const_sel),
    .xf_busy_o(xf_busy), .xf_done_o(xf_done), .xf_timeout_o(xf_timeout),
    .pwm_req_i(pwm_req), .pwm_gnt_o(pwm_gnt), .rns_req_i(rns_req), .rns_gnt_o(rns_gnt),
    .ut_rst_o(ut_rst), .ut_rst_pwm_o(ut_rst_pwm), .ut_is_fft_o(ut_is_fft), .ut_is_dif_o(ut_is_dif),
    .ut_current_k_o(ut_current_k), .ut_current_n_o(ut_current_n), .ut_qm_o(ut_qm),
    .ut_constants_sel_o(ut_constants_sel), .ut_done_i(ut_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: once the start is sampled and both grants are gone, ut_rst stays high for
  // DRAIN_C quiet cycles plus RST_C reset cycles, then falls.
  function automatic int exp_fall(input int start_edge, input int gnt_zero_edge);
    int base;
    base = (start_edge > gnt_zero_edge) ? start_edge : gnt_zero_edge;
    return base + DRAIN_C + RST_C;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    logic [31:0] r, rq, rn;
    r  = $urandom;
    rq = $urandom;
    rn = $urandom_range(0, 2);
    c.fft = r[0];
    c.dif = r[1];
    c.k   = r[5:2];
    c.n   = rn[1:0];
    c.qm  = rq[M-1:0];
    c.cs  = r[10:6];
    return c;
  endfunction

  function automatic cfg_t dut_cfg();
    return {ut_is_fft, ut_is_dif, ut_current_k, ut_current_n, ut_qm, ut_constants_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_start(input cfg_t c);
    xf_is_fft = c.fft; xf_is_dif = c.dif; xf_k = c.k; xf_n = c.n; xf_qm = c.qm; xf_const_sel = c.cs;
    xf_start = 1'b1;
    tick();
    xf_start = 1'b0;
  endtask

  task automatic wait_rst_fall(output int c, output bit ok);
    ok = 1'b0;
    c  = -1;
    for (int i = 0; i < 400; i++) begin
      if (ut_rst === 1'b0) begin
        c  = cyc;
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic finish_job();
    ut_done = 1'b1;
    tick();
    ut_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ticks(3);
    total++;
    if ({xf_busy, xf_done, xf_timeout, pwm_gnt, rns_gnt, ut_rst, ut_rst_pwm} !== 7'b0000011) begin
      bad++; $display("FAIL reset_flags: got %b want 0000011",
                      {xf_busy, xf_done, xf_timeout, pwm_gnt, rns_gnt, ut_rst, ut_rst_pwm});
    end
    total++;
    if (dut_cfg() !== '0) begin bad++; $display("FAIL reset_cfg: got %h want 0", dut_cfg()); end
    rst_n = 1'b1;
    tick();
    total++;
    if ({xf_busy, ut_rst, ut_rst_pwm, pwm_gnt} !== 4'b0110) begin
      bad++; $display("FAIL post_reset_idle: got %b want 0110", {xf_busy, ut_rst, ut_rst_pwm, pwm_gnt});
    end
  endtask

  task automatic test_basic();
    cfg_t c;
    int d, s, f, t;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      c = rand_cfg();
      if (it == 0) begin c.fft = 1'b1; c.dif = 1'b1; c.n = 2'd2; end
      d = (it == 0) ? 75 : (it == 1) ? 0 : (it == 2) ? WD_MAX : int'($urandom_range(1, WD_MAX - 1));
      t = cyc;
      drive_start(c);
      s = cyc;
      total++;
      if (xf_busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", xf_busy); end
      total++;
      if (dut_cfg() !== c) begin bad++; $display("FAIL basic_cfg: got %h want %h", dut_cfg(), c); end
      wait_rst_fall(f, ok);
      total++;
      if (!ok || f != exp_fall(s, 0) || f != t + 25) begin
        bad++; $display("FAIL basic_rst_fall: got %0d want %0d", f - t, exp_fall(s, 0) - t);
      end
      ticks(d);
      total++;
      if (ut_rst !== 1'b0) begin bad++; $display("FAIL basic_run_rst: got %b want 0", ut_rst); end
      ut_done = 1'b1;
      #1;
      total++;
      if (xf_timeout !== 1'b0) begin bad++; $display("FAIL basic_done_wins: got %b want 0", xf_timeout); end
      tick();
      ut_done = 1'b0;
      total++;
      if ({xf_done, ut_rst, xf_busy} !== 3'b111) begin
        bad++; $display("FAIL basic_fin: got %b want 111", {xf_done, ut_rst, xf_busy});
      end
      tick();
      total++;
      if ({xf_done, xf_busy, ut_rst, xf_timeout} !== 4'b0010) begin
        bad++; $display("FAIL basic_idle: got %b want 0010", {xf_done, xf_busy, ut_rst, xf_timeout});
      end
      total++;
      if (dut_cfg() !== c) begin bad++; $display("FAIL basic_cfg_hold: got %h want %h", dut_cfg(), c); end
    end
  endtask

  task automatic test_drain();
    cfg_t c;
    int s, t, gap, hold, f;
    bit ok;
    for (int it = 0; it < 2; it++) begin
      pwm_req = 1'b1;
      rns_req = 1'b1;
      tick();
      total++;
      if ({pwm_gnt, rns_gnt, ut_rst_pwm} !== 3'b110) begin
        bad++; $display("FAIL drain_grant: got %b want 110", {pwm_gnt, rns_gnt, ut_rst_pwm});
      end
      c = rand_cfg();
      drive_start(c);
      s = cyc;
      hold = $urandom_range(5, 40);
      ticks(hold);
      total++;
      if ({ut_rst, xf_busy, pwm_gnt, rns_gnt} !== 4'b1111) begin
        bad++; $display("FAIL drain_hold: got %b want 1111", {ut_rst, xf_busy, pwm_gnt, rns_gnt});
      end
      gap = (it == 0) ? 5 : int'($urandom_range(1, 9));
      pwm_req = 1'b0;
      t = cyc;
      tick();
      total++;
      if ({pwm_gnt, rns_gnt, ut_rst_pwm} !== 3'b011) begin
        bad++; $display("FAIL drain_pwm_drop: got %b want 011", {pwm_gnt, rns_gnt, ut_rst_pwm});
      end
      ticks(gap - 1);
      rns_req = 1'b0;
      wait_rst_fall(f, ok);
      total++;
      if (!ok || f != exp_fall(s, t + gap + 1)) begin
        bad++; $display("FAIL drain_rst_fall: got %0d want %0d", f - t, exp_fall(s, t + gap + 1) - t);
      end
      finish_job();
    end
  endtask

  task automatic test_start_vs_req();
    int f;
    bit ok;
    xf_start = 1'b1;
    pwm_req  = 1'b1;
    tick();
    xf_start = 1'b0;
    total++;
    if ({pwm_gnt, xf_busy} !== 2'b01) begin
      bad++; $display("FAIL race_job_wins: got %b want 01", {pwm_gnt, xf_busy});
    end
    wait_rst_fall(f, ok);
    total++;
    if (!ok || pwm_gnt !== 1'b0) begin bad++; $display("FAIL race_no_gnt_run: got %b want 0", pwm_gnt); end
    ut_done = 1'b1;
    tick();
    ut_done = 1'b0;
    total++;
    if ({pwm_gnt, xf_done} !== 2'b01) begin bad++; $display("FAIL race_fin: got %b want 01", {pwm_gnt, xf_done}); end
    tick();
    total++;
    if ({pwm_gnt, xf_busy} !== 2'b00) begin bad++; $display("FAIL race_idle: got %b want 00", {pwm_gnt, xf_busy}); end
    tick();
    total++;
    if ({pwm_gnt, ut_rst_pwm} !== 2'b10) begin
      bad++; $display("FAIL race_late_gnt: got %b want 10", {pwm_gnt, ut_rst_pwm});
    end
    pwm_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    cfg_t c;
    int f, tc, ndone;
    bit ok;
    c = rand_cfg();
    drive_start(c);
    wait_rst_fall(f, ok);
    tc = -1;
    ndone = 0;
    for (int i = 0; i < WD_MAX + 20; i++) begin
      if (xf_done === 1'b1) ndone++;
      if (xf_timeout === 1'b1) begin tc = cyc; break; end
      tick();
    end
    total++;
    if (!ok || tc != f + WD_MAX) begin bad++; $display("FAIL timeout_time: got %0d want %0d", tc - f, WD_MAX); end
    tick();
    if (xf_done === 1'b1) ndone++;
    total++;
    if ({xf_timeout, ut_rst, xf_busy} !== 3'b010) begin
      bad++; $display("FAIL timeout_after: got %b want 010", {xf_timeout, ut_rst, xf_busy});
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL timeout_no_done: got %0d want 0", ndone); end
    c = rand_cfg();
    drive_start(c);
    total++;
    if (xf_busy !== 1'b1 || dut_cfg() !== c) begin
      bad++; $display("FAIL timeout_restart: got %b/%h want 1/%h", xf_busy, dut_cfg(), c);
    end
    wait_rst_fall(f, ok);
    finish_job();
  endtask

  task automatic test_ignore_start();
    cfg_t a, b;
    int f, ndone;
    bit ok;
    a = rand_cfg();
    drive_start(a);
    wait_rst_fall(f, ok);
    ticks(3);
    b = rand_cfg();
    b.qm = a.qm ^ 17'h1;
    b.k  = a.k + 4'd1;
    drive_start(b);
    total++;
    if (dut_cfg() !== a || xf_busy !== 1'b1 || ut_rst !== 1'b0) begin
      bad++; $display("FAIL ignore_cfg: got %h want %h", dut_cfg(), a);
    end
    ticks(2);
    ut_done = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ut_done = 1'b0;
      if (xf_done === 1'b1) ndone++;
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL ignore_one_done: got %0d want 1", ndone); end
    total++;
    if (dut_cfg() !== a || xf_busy !== 1'b0) begin
      bad++; $display("FAIL ignore_cfg_idle: got %h want %h", dut_cfg(), a);
    end
  endtask

  task automatic test_async_reset();
    cfg_t c;
    int f;
    bit ok;
    c = rand_cfg();
    drive_start(c);
    wait_rst_fall(f, ok);
    ticks(4);
    pwm_req = 1'b1;
    ticks(2);
    total++;
    if (pwm_gnt !== 1'b0) begin bad++; $display("FAIL areset_no_gnt_run: got %b want 0", pwm_gnt); end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({xf_busy, xf_done, xf_timeout, pwm_gnt, rns_gnt, ut_rst, ut_rst_pwm} !== 7'b0000011 ||
        dut_cfg() !== '0) begin
      bad++; $display("FAIL areset_immediate: got %b/%h want 0000011/0",
                      {xf_busy, xf_done, xf_timeout, pwm_gnt, rns_gnt, ut_rst, ut_rst_pwm}, dut_cfg());
    end
    tick();
    #3 rst_n = 1'b1;
    tick();
    total++;
    if ({pwm_gnt, ut_rst_pwm, ut_rst, xf_busy, xf_done} !== 5'b10100) begin
      bad++; $display("FAIL areset_regrant: got %b want 10100", {pwm_gnt, ut_rst_pwm, ut_rst, xf_busy, xf_done});
    end
    pwm_req = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; xf_start = 1'b0; xf_is_fft = 1'b0; xf_is_dif = 1'b0; xf_k = '0; xf_n = '0;
    xf_qm = '0; xf_const_sel = '0; pwm_req = 1'b0; rns_req = 1'b0; ut_done = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_drain();
    test_start_vs_req();
    test_timeout();
    test_ignore_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL global_time_limit: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
